cache_miss_ctrl: RTL
====================

# cache_miss_ctrl

Memory-side miss/write-back controller between the fully-associative cache and the single-port `ramlpm` main memory. The cache issues one request per miss, carrying an optional dirty victim and the address to fill. The controller performs the write-back first, if one is needed, then performs the fill read. It returns the fill word with a one-cycle valid pulse and keeps saturating miss and write-back counters for display on LEDs/HEX.

## Interface
- `ADDR_W`, 7: memory/tag address width.
- `DATA_W`, 5: block (word) width.
- `RD_LAT`, 1: RAM read latency in cycles after the address-register edge; legal range 1..3.
- `CNT_W`, 8: width of the statistics counters.

Ports:
- `Clock`  in  1  single clock; all state changes on the rising edge.
- `Resetn`  in  1  asynchronous, active-low reset.
- `ReqValid`  in  1  cache miss request.
- `ReqReady`  out  1  controller can accept a request; high only in IDLE.
- `ReqDirty`  in  1  victim needs write-back.
- `ReqWbAddr`  in  ADDR_W  victim address.
- `ReqWbData`  in  DATA_W  victim data.
- `ReqFillAddr`  in  ADDR_W  address to fetch.
- `FillValid`  out  1  one-cycle pulse; `FillData` is valid.
- `FillData`  out  DATA_W  fetched word, held until the next fill.
- `MemAddr`  out  ADDR_W  RAM address.
- `MemWrData`  out  DATA_W  RAM write data.
- `MemWrite`  out  1  RAM write enable.
- `MemRdData`  in  DATA_W  RAM read data.
- `Busy`  out  1  equals the inverse of `ReqReady`.
- `MissCount`  out  CNT_W  number of accepted requests, saturating.
- `WbCount`  out  CNT_W  number of accepted dirty requests, saturating.

## Operation
- **States:** IDLE, WB, RD, WAIT.
- **Accept:** a request is accepted on the edge where `ReqValid & ReqReady`.
  - All `Req*` fields are registered at that edge.
  - Request inputs are don't-care at every other time.
  - `ReqValid` while `Busy` is ignored; no queueing.
- **IDLE → WB** when the accepted request has `ReqDirty=1`; **IDLE → RD** otherwise.
- **WB (one cycle):**
  - `MemWrite=1`, `MemAddr`=victim address, `MemWrData`=victim data.
  - Next state is RD.
- **RD (one cycle):**
  - `MemWrite=0`, `MemAddr`=fill address.
  - Next state is WAIT, with the wait counter loaded to `RD_LAT-1`.
- **WAIT:**
  - `MemAddr` stays at the fill address; `MemWrite=0`.
  - The counter decrements each cycle.
  - On the edge where the counter equals 0: `FillData <= MemRdData`, `FillValid <= 1`, state → IDLE.
- **FillValid** is high for exactly the first IDLE cycle and cleared on the next edge.
- **Back-to-back:** a new request may be accepted in the same cycle `FillValid` is high.
- **MemWrite** is high only in WB. It is never high in two consecutive cycles.
- **Counters:**
  - `MissCount` increments at every accept.
  - `WbCount` increments at every accept with `ReqDirty=1`.
  - Both hold at all-ones, with no wrap.
- **Reset (asynchronous, effective immediately, including mid-operation):**
  - State → IDLE.
  - `ReqReady=1`, `Busy=0`.
  - `MemWrite=0`, `MemAddr=0`, `MemWrData=0`.
  - `FillValid=0`, `FillData=0`.
  - Both counters = 0.
  - An interrupted request is dropped: no `FillValid`, no retry.

## Timing
- Edges are numbered E0 (accept), E1, E2, …
- **Clean miss:**
  - RD cycle is E0–E1.
  - WAIT cycles run E1 to E(1+RD_LAT).
  - `FillValid` is high in the cycle after E(1+RD_LAT); with `RD_LAT=1`, that is after E2.
- **Dirty miss:**
  - WB cycle is E0–E1, which adds one cycle.
  - `FillValid` is high after E(2+RD_LAT).
- **ReqReady** falls immediately after E0. It rises in the same cycle as `FillValid`.
- **Throughput:** one request per 2+RD_LAT cycles (clean) or 3+RD_LAT cycles (dirty).
- **All outputs are registered;** there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert `Resetn=0`, release it, hold `ReqValid=0` → all outputs at their reset values, `ReqReady=1`, counters 0.
- **Clean miss:** RAM preloaded with mem[0x64]=0x05; request `ReqDirty=0`, `ReqFillAddr=0x64`, `RD_LAT=1` → `MemWrite` never high; `FillValid` pulse after E2 with `FillData=0x05`; `MissCount=1`, `WbCount=0`.
- **Dirty miss:** request `ReqDirty=1`, `WbAddr=0x65`, `WbData=0x03`, `FillAddr=0x69` → `MemWrite=1` for exactly one cycle (E0–E1) with `MemAddr=0x65`, `MemWrData=0x03`; `FillData`=mem[0x69] after E3; afterwards mem[0x65]=0x03; `WbCount=1`.
- **Busy and back-to-back:** toggle `ReqValid` and change `Req*` fields while `Busy` → ignored, and the captured fill address is the one used. A second request presented in the `FillValid` cycle → accepted at that edge.
- **Reset mid-operation:** pulse `Resetn` low during the WB cycle → `MemWrite` drops asynchronously, no `FillValid` ever appears, `ReqReady=1`. Repeat with a reset pulse during WAIT → same result.
- **Saturation and latency sweep:** issue 300 dirty requests → both counters hold at 255. Repeat the clean-miss latency check with `RD_LAT=3` → `FillValid` after E4.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss/write-back controller between the cache and a single-port RAM.
// Write-back (if dirty) happens before the fill read; fill returns with a one-cycle pulse.
module cache_miss_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 5,
  parameter int RD_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqDirty,
  input  logic [ADDR_W-1:0] ReqWbAddr,
  input  logic [DATA_W-1:0] ReqWbData,
  input  logic [ADDR_W-1:0] ReqFillAddr,
  output logic              FillValid,
  output logic [DATA_W-1:0] FillData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWrData,
  output logic              MemWrite,
  input  logic [DATA_W-1:0] MemRdData,
  output logic              Busy,
  output logic [CNT_W-1:0]  MissCount,
  output logic [CNT_W-1:0]  WbCount
);

  // Handshake: a request transfers on the rising edge where ReqValid & ReqReady.
  typedef enum logic [1:0] {IDLE, WB, RD, WAIT} state_t;

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        wait_cnt;
  logic [ADDR_W-1:0] fill_addr_q;

  assign ReqReady = (state == IDLE);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ReqValid) state_nxt = ReqDirty ? WB : RD;
      WB:      state_nxt = RD;
      RD:      state_nxt = WAIT;
      WAIT:    if (wait_cnt == 2'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Memory-side outputs are registered one edge ahead so they line up with the state.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wait_cnt    <= 2'd0;
      fill_addr_q <= '0;
      FillValid   <= 1'b0;
      FillData    <= '0;
      MemAddr     <= '0;
      MemWrData   <= '0;
      MemWrite    <= 1'b0;
      MissCount   <= '0;
      WbCount     <= '0;
    end else begin
      FillValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            fill_addr_q <= ReqFillAddr;
            if (MissCount != '1) MissCount <= MissCount + 1'b1;
            if (ReqDirty) begin
              MemWrite  <= 1'b1;
              MemAddr   <= ReqWbAddr;
              MemWrData <= ReqWbData;
              if (WbCount != '1) WbCount <= WbCount + 1'b1;
            end else begin
              MemAddr <= ReqFillAddr;
            end
          end
        end
        WB: begin
          MemWrite <= 1'b0;
          MemAddr  <= fill_addr_q;
        end
        RD: wait_cnt <= WAIT_INIT;
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            FillData  <= MemRdData;
            FillValid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
